// File: rtl/layer_output_serializer.sv
// Captures one layer's parallel neuron outputs on a common valid strobe and
// replays them as a gap-free serial word stream, neuron 0 first.
module layer_output_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]            neuron_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic                              busy,
    output logic                              overrun,
    output logic                              valid_mismatch
);

    localparam int CNT_WIDTH = $clog2(NUM_NEURONS);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                               state;
    state_t                               next_state;
    logic [CNT_WIDTH-1:0]                 cnt;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] sr;
    logic                                 overrun_q;
    logic                                 mismatch_q;

    logic cap;
    logic partial;
    logic last;
    logic load;
    logic advance;
    logic drop;

    always_comb begin
        cap     = &neuron_valid;
        partial = (|neuron_valid) && !cap;
        last    = (cnt == LAST_IDX);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (cap) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    // A frame landing on the last word reloads seamlessly.
                    if (cap) begin
                        load = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    advance = 1'b1;
                    drop    = cap;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shift register, index counter and sticky flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr         <= '0;
            cnt        <= '0;
            overrun_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            if (load) begin
                sr  <= neuron_out;
                cnt <= '0;
            end else if (advance) begin
                // Leaving SHIFT does not shift, so out_data holds the last word.
                sr  <= {{DATA_WIDTH{1'b0}}, sr[NUM_NEURONS-1:1]};
                cnt <= cnt + 1'b1;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
            if (partial) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        out_valid      = (state == SHIFT);
        busy           = (state == SHIFT);
        out_data       = sr[0];
        overrun        = overrun_q;
        valid_mismatch = mismatch_q;
    end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer with NUM_NEURONS=4, DATA_WIDTH=16.
module tb_layer_output_serializer;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] neuron_out;
    logic [N-1:0]   neuron_valid;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           busy;
    logic           overrun;
    logic           valid_mismatch;

    int checks;
    int errors;

    layer_output_serializer #(
        .NUM_NEURONS(N),
        .DATA_WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .neuron_out    (neuron_out),
        .neuron_valid  (neuron_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun),
        .valid_mismatch(valid_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [W-1:0] w);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(w));
    endtask

    task automatic expect_idle(input string tag, input logic [W-1:0] w,
                               input logic ovr, input logic mis);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'(w));
        check({tag, "_overrun"}, 32'(overrun), 32'(ovr));
        check({tag, "_mismatch"}, 32'(valid_mismatch), 32'(mis));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        neuron_valid = '0;
        neuron_out   = '0;
        step();
        step();
        expect_idle("reset", 16'h0000, 1'b0, 1'b0);

        rst = 1'b1;
        step();
        expect_idle("post_reset", 16'h0000, 1'b0, 1'b0);

        // Frame 1 then back-to-back frame 2 captured on the last word.
        neuron_out   = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        neuron_valid = 4'hF;
        step();
        neuron_valid = '0;
        expect_word("f1_w0", 16'h0001);
        step();
        expect_word("f1_w1", 16'h0002);
        step();
        expect_word("f1_w2", 16'h0003);
        step();
        expect_word("f1_w3", 16'h0004);
        neuron_out   = {16'h00D0, 16'h00C0, 16'h00B0, 16'h00A0};
        neuron_valid = 4'hF;
        step();
        neuron_valid = '0;
        expect_word("f2_w0", 16'h00A0);
        step();
        expect_word("f2_w1", 16'h00B0);
        step();
        expect_word("f2_w2", 16'h00C0);
        step();
        expect_word("f2_w3", 16'h00D0);
        step();
        expect_idle("b2b_end", 16'h00D0, 1'b0, 1'b0);
        step();
        expect_idle("b2b_hold", 16'h00D0, 1'b0, 1'b0);

        // Overrun: second capture at cnt=1 is dropped.
        neuron_out   = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        neuron_valid = 4'hF;
        step();
        neuron_valid = '0;
        expect_word("ov_w0", 16'h0001);
        step();
        expect_word("ov_w1", 16'h0002);
        neuron_out   = {16'h0099, 16'h0088, 16'h0077, 16'h0066};
        neuron_valid = 4'hF;
        step();
        neuron_valid = '0;
        expect_word("ov_w2", 16'h0003);
        check("ov_flag_set", 32'(overrun), 32'd1);
        step();
        expect_word("ov_w3", 16'h0004);
        step();
        expect_idle("ov_end", 16'h0004, 1'b1, 1'b0);
        step();
        expect_idle("ov_sticky", 16'h0004, 1'b1, 1'b0);

        // Partial valid strobe: no capture, mismatch flag set.
        neuron_out   = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        neuron_valid = 4'b0101;
        step();
        neuron_valid = '0;
        expect_idle("mis_set", 16'h0004, 1'b1, 1'b1);
        step();
        expect_idle("mis_sticky", 16'h0004, 1'b1, 1'b1);

        // Reset in the middle of a replay.
        neuron_out   = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        neuron_valid = 4'hF;
        step();
        neuron_valid = '0;
        expect_word("rm_w0", 16'h0010);
        step();
        expect_word("rm_w1", 16'h0020);
        step();
        expect_word("rm_w2", 16'h0030);
        rst = 1'b0;
        step();
        expect_idle("rm_reset", 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        expect_idle("rm_after", 16'h0000, 1'b0, 1'b0);

        // Fresh frame with sign-bit patterns replays bit-exact from neuron 0.
        neuron_out   = {16'h1234, 16'h7FFF, 16'hFFFF, 16'h8000};
        neuron_valid = 4'hF;
        step();
        neuron_valid = '0;
        expect_word("sg_w0", 16'h8000);
        step();
        expect_word("sg_w1", 16'hFFFF);
        step();
        expect_word("sg_w2", 16'h7FFF);
        step();
        expect_word("sg_w3", 16'h1234);
        step();
        expect_idle("sg_end", 16'h1234, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_output_serializer.md
Name: layer_output_serializer

Overview:
- Sits directly downstream of one layer of neurons.
- Captures the parallel outputs of all NUM_NEURONS neurons in that layer when they assert their output-valid strobes together.
- Replays the outputs as a serial word stream, neuron 0 first, one word per cycle.
- The stream drives the next layer's neuron data-input and input-valid pins, which take no backpressure.

Parameters:
- NUM_NEURONS, 30, number of neurons in the feeding layer (>=2).
- DATA_WIDTH, 16, width of each neuron output and of the serial output word.
- CNT_WIDTH, $clog2(NUM_NEURONS), derived; index counter width. Not to be overridden.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- neuron_out  input  NUM_NEURONS*DATA_WIDTH  packed neuron outputs; neuron i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- neuron_valid  input  NUM_NEURONS  per-neuron output-valid strobes; single-cycle pulses.
- out_data  output  DATA_WIDTH  serial data word to the next layer.
- out_valid  output  1  qualifies out_data; high for exactly NUM_NEURONS consecutive cycles per captured frame.
- busy  output  1  high while a frame is being replayed (equals out_valid).
- overrun  output  1  sticky; a frame arrived while a replay was still in progress and was dropped.
- valid_mismatch  output  1  sticky; neuron_valid seen neither all-ones nor all-zeros on some cycle.

Behaviour:
- Reset (rst==0 at an edge):
  - state<=IDLE, cnt<=0, shift register<=0.
  - out_data=0, out_valid=0, busy=0, overrun=0, valid_mismatch=0.
  - Reset overrides everything, including a replay in progress; the partial frame is discarded and no further out_valid pulses occur.
- Capture condition: cap = &neuron_valid.
  - If neuron_valid is nonzero but not all-ones, set valid_mismatch and do not capture.
- State machine, two states:
  - IDLE: on cap, load the shift register with all words, set cnt<=0, go to SHIFT.
  - SHIFT: each cycle, shift one word towards the output slot and set cnt<=cnt+1.
    - At cnt==NUM_NEURONS-1 (last word presented): if cap is high, reload and stay in SHIFT with cnt<=0, giving seamless back-to-back frames; otherwise go to IDLE.
    - On cap at any cnt < NUM_NEURONS-1: drop the new frame, set overrun<=1, and continue the current replay unchanged.
- Outputs are registered:
  - out_data is shift-register slot 0.
  - out_valid = (state==SHIFT).
- Latency: if cap is sampled at edge E, word k (neuron k) appears on out_data with out_valid=1 during the cycle after edge E+k, for k=0..NUM_NEURONS-1. The first word appears 1 cycle after capture.
- The words form a contiguous burst with no gaps. out_valid falls after the last word unless a back-to-back reload occurs.
- In IDLE, out_data holds its last value. Consumers must qualify out_data with out_valid only.
- No arithmetic is performed; words pass bit-exact (signed fixed point is preserved as opaque bits).
- Sticky flags clear only on reset.
- cnt never exceeds NUM_NEURONS-1; there is no wrap-around beyond a frame.

Test Plan:
- NUM_NEURONS=4, DATA_WIDTH=16. Reset, then pulse neuron_valid=4'hF with words {0x0004,0x0003,0x0002,0x0001} (neuron0=0x0001) -> out_valid high exactly 4 cycles starting 1 cycle after capture; out_data 0x0001, 0x0002, 0x0003, 0x0004; busy tracks out_valid; both flags stay 0.
- Back-to-back: a second frame {0x00D0,0x00C0,0x00B0,0x00A0} captured on the cycle the last word 0x0004 is presented -> out_valid stays high 8 consecutive cycles; the second frame 0x00A0..0x00D0 follows with no gap; overrun=0.
- Overrun: a second cap arrives 1 cycle into the replay (cnt=1) -> the first frame completes unchanged (4 words); overrun=1 and stays 1; the dropped frame never appears; out_valid falls after 4 cycles.
- Mismatch: neuron_valid=4'b0101 for one cycle -> no capture, out_valid stays 0, valid_mismatch=1 (sticky).
- Reset mid-replay: rst=0 at cnt=2 -> next cycle out_valid=0, out_data=0, busy=0, flags 0. A fresh frame afterwards replays normally from neuron 0.
- Sign preservation: capture words 0x8000 and 0xFFFF -> emitted bit-exact.
